// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory and the IF/ID register.
// master = fetch_queue side, slave = memory/consumer side.
interface fetch_queue_if;
    // Transfers complete on a rising edge where both sides are high: imem_req & imem_gnt
    // issues a fetch, and out_valid & out_ready consumes the head. imem_rvalid has no
    // back-pressure. A flush may withdraw imem_req and out_valid without a transfer.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_4;
    logic [31:0] out_instr;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  flush, flush_pc,
        output out_valid, out_pc, out_pc_4, out_instr,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output flush, flush_pc,
        input  out_valid, out_pc, out_pc_4, out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID: issues sequential fetches, buffers returned
// words with PC/PC+4, and discards responses that belong to a pre-flush fetch stream.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master fq
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW:0]   drop_sum;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   flush_target;
    logic          out_valid_q;
    logic [31:0]   out_pc_q;
    logic [31:0]   out_pc_4_q;
    logic [31:0]   out_instr_q;
    logic          req;
    logic          issue;
    logic          rsp_drop;
    logic          rsp_take;
    logic          push;
    logic          pop;

    always_comb begin
        req          = ~reset & ~fq.flush & (({1'b0, count} + {1'b0, outstanding}) < CAP);
        issue        = req & fq.imem_gnt;
        rsp_drop     = fq.imem_rvalid & (drop != '0);
        rsp_take     = fq.imem_rvalid & (drop == '0);
        push         = rsp_take & ~fq.flush;
        pop          = out_valid_q & fq.out_ready & ~fq.flush;
        count_n      = count + CW'(push) - CW'(pop);
        head_nxt     = head + PW'(1);
        // Everything still in flight at a flush becomes stale, less the response landing now.
        drop_sum     = {1'b0, drop} + {1'b0, outstanding} - (CW+1)'(fq.imem_rvalid);
        flush_target = fq.flush_pc & ~32'h3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_pc_4_q  <= '0;
            out_instr_q <= '0;
        end else if (fq.flush) begin
            fetch_pc    <= flush_target;
            resp_pc     <= flush_target;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= drop_sum[CW-1:0];
            out_valid_q <= 1'b0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PW'(1);
            end
            if (pop) head <= head_nxt;
            count       <= count_n;
            outstanding <= outstanding + CW'(issue) - CW'(rsp_take);
            drop        <= drop - CW'(rsp_drop);
            out_valid_q <= (count_n != '0);
            // Head registers track the entry that will be at the head next cycle; when
            // that entry is the one arriving now, it is taken from the response bus.
            if (pop && count > CW'(1)) begin
                out_pc_q    <= pc_mem[head_nxt];
                out_pc_4_q  <= pc_mem[head_nxt] + 32'd4;
                out_instr_q <= instr_mem[head_nxt];
            end else if (push && (count == '0 || (pop && count == CW'(1)))) begin
                out_pc_q    <= resp_pc;
                out_pc_4_q  <= resp_pc + 32'd4;
                out_instr_q <= fq.imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[tail]    <= resp_pc;
            instr_mem[tail] <= fq.imem_rdata;
        end
    end

    assign fq.imem_req  = req;
    assign fq.imem_addr = fetch_pc;
    assign fq.out_valid = out_valid_q;
    assign fq.out_pc    = out_pc_q;
    assign fq.out_pc_4  = out_pc_4_q;
    assign fq.out_instr = out_instr_q;

    // The issue rule keeps count + outstanding <= DEPTH, so these only fire on misuse.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(fq.imem_rvalid && drop == '0 && outstanding == '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && count == FULL));
    a_drop_range: assert property (@(posedge clk) disable iff (reset)
        !(fq.flush && drop_sum[CW]));
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model, queue-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fetch_queue_if fq();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_rand = 1'b0;
    int n_issued = 0;
    logic [31:0] pop_log[$];
    logic [31:0] pc4_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model: in-order, fixed latency ----------------
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    initial begin : memory
        pend_t p;
        forever begin
            @(negedge clk);
            if (reset) pend.delete();
            else begin
                if (fq.imem_rvalid && pend.size() > 0) void'(pend.pop_front());
                if (fq.imem_req && fq.imem_gnt) begin
                    p.addr = fq.imem_addr;
                    p.due  = cyc + lat;
                    pend.push_back(p);
                    n_issued++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        fq.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            fq.imem_rvalid = 1'b1;
            fq.imem_rdata  = mem_word(pend[0].addr);
        end else begin
            fq.imem_rvalid = 1'b0;
            fq.imem_rdata  = '0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        #1;
        check("reset out_valid", 32'(fq.out_valid), 32'h0);
        check("reset out_pc", fq.out_pc, 32'h0);
        check("reset out_pc_4", fq.out_pc_4, 32'h0);
        check("reset out_instr", fq.out_instr, 32'h0);
        check("reset imem_req", 32'(fq.imem_req), 32'h0);
        reset = 1'b0;
    endtask

    // ---------------- scoreboard: queue-level reference model ----------------
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    logic [31:0] exp_q[$];
    fl_t         infl[$];

    initial begin : scoreboard
        logic [31:0] m_fetch_pc, h_pc, h_pc4, h_instr;
        logic [31:0] e_pc, e_pc4, e_instr;
        logic        exp_req;
        bit          armed;
        int          live;
        fl_t         e;
        armed = 1'b0;
        m_fetch_pc = '0; h_pc = '0; h_pc4 = '0; h_instr = '0;
        forever begin
            @(negedge clk);
            live = 0;
            foreach (infl[i]) if (!infl[i].stale) live++;
            exp_req = !reset && !fq.flush && (exp_q.size() + live < DEPTH);
            if (exp_q.size() > 0) begin
                e_pc = exp_q[0]; e_pc4 = exp_q[0] + 32'd4; e_instr = mem_word(exp_q[0]);
            end else begin
                e_pc = h_pc; e_pc4 = h_pc4; e_instr = h_instr;
            end
            if (armed) begin
                check("imem_req", 32'(fq.imem_req), 32'(exp_req));
                if (exp_req) check("imem_addr", fq.imem_addr, m_fetch_pc);
                check("out_valid", 32'(fq.out_valid), 32'(exp_q.size() > 0));
                check("out_pc", fq.out_pc, e_pc);
                check("out_pc_4", fq.out_pc_4, e_pc4);
                check("out_instr", fq.out_instr, e_instr);
                if (!reset && fq.out_valid && fq.out_ready && !fq.flush) begin
                    pop_log.push_back(fq.out_pc);
                    pc4_log.push_back(fq.out_pc_4);
                end
            end
            h_pc = e_pc; h_pc4 = e_pc4; h_instr = e_instr;
            if (reset) begin
                exp_q.delete();
                infl.delete();
                m_fetch_pc = 32'h0;
                h_pc = '0; h_pc4 = '0; h_instr = '0;
                armed = 1'b1;
            end else begin
                if (!fq.flush && fq.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (fq.imem_rvalid && infl.size() > 0) begin
                    e = infl.pop_front();
                    if (!e.stale && !fq.flush) exp_q.push_back(e.pc);
                end
                if (fq.flush) begin
                    exp_q.delete();
                    foreach (infl[i]) infl[i].stale = 1'b1;
                    m_fetch_pc = fq.flush_pc & ~32'h3;
                end else if (exp_req && fq.imem_gnt) begin
                    e.pc = m_fetch_pc;
                    e.stale = 1'b0;
                    infl.push_back(e);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        fq.imem_gnt = 1'b1; fq.imem_rvalid = 1'b0; fq.imem_rdata = '0;
        fq.flush = 1'b0; fq.flush_pc = '0; fq.out_ready = 1'b1;

        // streaming with 1-cycle memory
        lat = 1; gnt_rand = 1'b0;
        do_reset(3);
        #1;
        check("t1 first req", 32'(fq.imem_req), 32'h1);
        check("t1 first addr", fq.imem_addr, 32'h0);
        tick(); #1;
        check("t1 second addr", fq.imem_addr, 32'h4);
        check("t1 valid latency", 32'(fq.out_valid), 32'h0);
        tick(); #1;
        check("t1 first valid", 32'(fq.out_valid), 32'h1);
        check("t1 first pc", fq.out_pc, 32'h0);
        check("t1 first pc_4", fq.out_pc_4, 32'h4);
        check("t1 first instr", fq.out_instr, 32'hFFFF_FFFF);
        for (int k = 1; k < 6; k++) begin
            tick(); #1;
            check("t1 stream pc", fq.out_pc, 32'(4 * k));
        end

        // consumer stalled: exactly DEPTH requests, head held
        fq.out_ready = 1'b0;
        do_reset(2);
        n_issued = 0;
        repeat (10) tick();
        #1;
        check("t2 issued count", 32'(n_issued), 32'd4);
        check("t2 req held low", 32'(fq.imem_req), 32'h0);
        check("t2 head pc", fq.out_pc, 32'h0);
        pop_log.delete();
        fq.out_ready = 1'b1;
        repeat (8) tick();
        check("t2 pops seen", 32'(pop_log.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) check("t2 order", pop_log[i], 32'(4 * i));

        // flush with three requests in flight on a 3-cycle memory
        lat = 3;
        do_reset(2);
        tick(); tick(); tick();
        fq.flush = 1'b1; fq.flush_pc = 32'h103;
        #1;
        check("t3 req off in flush", 32'(fq.imem_req), 32'h0);
        tick();
        fq.flush = 1'b0;
        pop_log.delete();
        #1;
        check("t3 redirect addr", fq.imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t3 no stale output", 32'(fq.out_valid), 32'h0);
        end
        tick(); #1;
        check("t3 first new valid", 32'(fq.out_valid), 32'h1);
        check("t3 first new pc", fq.out_pc, 32'h100);
        check("t3 first new instr", fq.out_instr, ~32'h100);

        // flush coinciding with a response and a pop
        lat = 1;
        do_reset(2);
        repeat (6) tick();
        #1;
        check("t4 streaming", 32'(fq.imem_rvalid & fq.out_valid), 32'h1);
        fq.flush = 1'b1; fq.flush_pc = 32'h200;
        tick();
        fq.flush = 1'b0;
        pop_log.delete();
        #1;
        check("t4 valid dropped", 32'(fq.out_valid), 32'h0);
        tick(); #1;
        check("t4 still empty", 32'(fq.out_valid), 32'h0);
        tick(); #1;
        check("t4 new pc", fq.out_pc, 32'h200);
        repeat (3) tick();
        check("t4 log head", pop_log[0], 32'h200);

        // random grant and stall, back-to-back flushes
        lat = 2; gnt_rand = 1'b1;
        do_reset(2);
        repeat (8) begin
            tick();
            fq.out_ready = 1'($urandom_range(0, 1));
        end
        tick(); fq.flush = 1'b1; fq.flush_pc = 32'h40;
        tick(); fq.flush_pc = 32'h80;
        tick(); fq.flush = 1'b0;
        pop_log.delete();
        repeat (40) begin
            tick();
            fq.out_ready = 1'($urandom_range(0, 1));
        end
        gnt_rand = 1'b0; fq.out_ready = 1'b1;
        repeat (10) tick();
        check("t5 pops seen", 32'(pop_log.size() > 4), 32'h1);
        foreach (pop_log[i]) check("t5 sequence", pop_log[i], 32'h80 + 32'(4 * i));

        // address wrap, then reset mid-stream
        lat = 1;
        tick();
        fq.flush = 1'b1; fq.flush_pc = 32'hFFFF_FFF8;
        tick();
        fq.flush = 1'b0;
        pop_log.delete(); pc4_log.delete();
        #1;
        check("t6 addr F8", fq.imem_addr, 32'hFFFF_FFF8);
        tick(); #1;
        check("t6 addr FC", fq.imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("t6 addr wrap", fq.imem_addr, 32'h0);
        repeat (3) tick();
        check("t6 pc F8", pop_log[0], 32'hFFFF_FFF8);
        check("t6 pc FC", pop_log[1], 32'hFFFF_FFFC);
        check("t6 pc 0", pop_log[2], 32'h0);
        check("t6 pc_4 FC", pc4_log[0], 32'hFFFF_FFFC);
        check("t6 pc_4 wrap", pc4_log[1], 32'h0);
        check("t6 pc_4 4", pc4_log[2], 32'h4);
        do_reset(1);
        #1;
        check("t6 restart req", 32'(fq.imem_req), 32'h1);
        check("t6 restart addr", fq.imem_addr, 32'h0);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
